uart_rx_arbiter: RTL and testbench

//  Shares one byte-wide downstream consumer among N_CH uart_receiver instances.
//  Per channel: latches each rx_done/rx_DATA byte into a 1-entry hold register.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_rx_arbiter_rr.sv | 44 ++++
 rtl/uart_rx_arbiter.sv | 83 ++++++++
 tb/tb_uart_rx_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared widths, default channel count and channel-id width helper
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int UART_N_CH   = 4;

  // A single-channel build still needs a 1-bit channel id.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_arbiter_rr.sv
// rtl/uart_rx_arbiter_rr.sv - round-robin grant over N requests, pointer moves only on advance
module rr_arbiter
  import uart_pkg::*;
#(
  parameter  int N = UART_N_CH,
  localparam int W = ch_width(N)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant_onehot,
  output logic [W-1:0] grant_idx,
  output logic         any
);

  logic [W-1:0] ptr;
  int           c;

  // Scan from the pointer upward, wrapping, and take the first requester.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    c            = 0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!any && req[c]) begin
        any             = 1'b1;
        grant_idx       = W'(c);
        grant_onehot[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && any) begin
      ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_arbiter.sv
// rtl/uart_rx_arbiter.sv - per-channel byte hold registers merged onto one tagged valid/ready stream
module uart_rx_arbiter
  import uart_pkg::*;
#(
  parameter  int N_CH   = UART_N_CH,
  parameter  int DATA_W = UART_DATA_W,
  localparam int CH_W   = ch_width(N_CH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_CH-1:0]        rx_done,
  input  logic [N_CH*DATA_W-1:0] rx_DATA,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [CH_W-1:0]        out_ch,
  output logic [N_CH-1:0]        overrun,
  input  logic [N_CH-1:0]        overrun_clr
);

  logic [DATA_W-1:0] hold_data [N_CH];
  logic [N_CH-1:0]   hold_full;
  logic [N_CH-1:0]   grant_onehot;
  logic [CH_W-1:0]   grant_idx;
  logic              any_full;
  logic              load;
  logic [N_CH-1:0]   granted;
  logic [N_CH-1:0]   ov_set;

  // out_ready only reaches register enables, never an output directly.
  assign load    = (!out_valid || out_ready) && any_full;
  assign granted = grant_onehot & {N_CH{load}};
  assign ov_set  = rx_done & hold_full & ~granted;

  rr_arbiter #(.N(N_CH)) u_rr (
    .clock        (clock),
    .reset        (reset),
    .req          (hold_full),
    .advance      (load),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (any_full)
  );

  // A channel being drained this edge can take a new byte without overrun.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_CH; i++) begin
      if (reset) begin
        hold_full[i] <= 1'b0;
        hold_data[i] <= '0;
      end else if (rx_done[i] && (!hold_full[i] || granted[i])) begin
        hold_full[i] <= 1'b1;
        hold_data[i] <= rx_DATA[i*DATA_W +: DATA_W];
      end else if (granted[i]) begin
        hold_full[i] <= 1'b0;
      end
    end
  end

  // Clear is applied first so a coincident drop keeps the flag set.
  always_ff @(posedge clock) begin
    if (reset) begin
      overrun <= '0;
    end else begin
      overrun <= (overrun & ~overrun_clr) | ov_set;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= hold_data[grant_idx];
      out_ch    <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_arbiter.sv
// tb/tb_uart_rx_arbiter.sv - directed and randomized checks of uart_rx_arbiter against a behavioural model
module tb_uart_rx_arbiter;

  localparam int N = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  rx_done = '0;
  logic [31:0] rx_data = '0;
  logic        out_ready = 1'b0;
  logic [3:0]  overrun_clr = '0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic [3:0]  overrun;

  int checks   = 0;
  int failures = 0;

  // behavioural model state: what the outputs must be after the latest edge
  bit m_full [N];
  int m_data [N];
  bit m_ov   [N];
  int m_ptr;
  bit m_valid;
  int m_odata;
  int m_och;
  bit chk_en = 1'b0;

  bit p_valid = 1'b0;
  int p_data  = 0;
  int p_ch    = 0;

  uart_rx_arbiter #(.N_CH(N), .DATA_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_done     (rx_done),
    .rx_DATA     (rx_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ch      (out_ch),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic [3:0] rx, input logic [31:0] dat,
                            input logic rdy, input logic [3:0] clr);
    int g;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_full[i] = 1'b0;
        m_data[i] = 0;
        m_ov[i]   = 1'b0;
      end
      m_ptr = 0; m_valid = 1'b0; m_odata = 0; m_och = 0;
      return;
    end
    g = -1;
    if (!m_valid || rdy) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && m_full[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    if (g >= 0) begin
      m_valid = 1'b1; m_odata = m_data[g]; m_och = g;
      m_full[g] = 1'b0; m_ptr = (g + 1) % N;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (clr[i]) m_ov[i] = 1'b0;
      if (rx[i]) begin
        if (m_full[i]) m_ov[i] = 1'b1;
        else begin
          m_full[i] = 1'b1;
          m_data[i] = int'(dat[i*8 +: 8]);
        end
      end
    end
  endtask

  task automatic cyc(input logic rst, input logic [3:0] rx, input logic [31:0] dat,
                     input logic rdy, input logic [3:0] clr);
    @(negedge clock);
    reset = rst; rx_done = rx; rx_data = dat; out_ready = rdy; overrun_clr = clr;
    model_step(rst, rx, dat, rdy, clr);
    @(posedge clock);
    #1;
  endtask

  // compare process: every cycle after the first reset edge
  always @(posedge clock) begin
    #2;
    if (chk_en) begin
      chk("out_valid", int'(out_valid), int'(m_valid));
      chk("out_data", int'(out_data), m_odata);
      chk("out_ch", int'(out_ch), m_och);
      for (int i = 0; i < N; i++) chk("overrun", int'(overrun[i]), int'(m_ov[i]));
      if (p_valid && !out_ready && !reset) begin
        chk("stable_data", int'(out_data), p_data);
        chk("stable_ch", int'(out_ch), p_ch);
      end
      p_valid = out_valid; p_data = int'(out_data); p_ch = int'(out_ch);
    end
  end

  initial begin
    int beat;
    logic [3:0] rrx;
    cyc(1, 4'b0000, 0, 0, 0);
    chk_en = 1'b1;
    cyc(1, 4'b1111, 32'hFFFF_FFFF, 0, 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_ch", int'(out_ch), 0);
    chk("rst_overrun", int'(overrun), 0);

    // single byte on ch2
    cyc(0, 4'b0100, 32'h00A5_0000, 0, 0);
    chk("t1_lat_t1", int'(out_valid), 0);
    cyc(0, 4'b0000, 0, 0, 0);
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_data", int'(out_data), 'hA5);
    chk("t1_ch", int'(out_ch), 2);
    cyc(0, 4'b0000, 0, 1, 0);
    chk("t1_ack", int'(out_valid), 0);

    // simultaneous bytes from all channels
    cyc(1, 4'b0000, 0, 0, 0);
    cyc(0, 4'b1111, 32'h1312_1110, 1, 0);
    for (int b = 0; b < 4; b++) begin
      cyc(0, 4'b0000, 0, 1, 0);
      chk("t2_ch", int'(out_ch), b);
      chk("t2_data", int'(out_data), 'h10 + b);
    end
    cyc(0, 4'b0000, 0, 1, 0);
    chk("t2_done", int'(out_valid), 0);
    chk("t2_no_ov", int'(overrun), 0);

    // backpressure on ch1
    cyc(0, 4'b0010, 32'h0000_5500, 0, 0);
    cyc(0, 4'b0000, 0, 0, 0);
    chk("t3_first", int'(out_data), 'h55);
    cyc(0, 4'b0010, 32'h0000_3300, 0, 0);
    cyc(0, 4'b0010, 32'h0000_6600, 0, 0);
    chk("t3_ov1", int'(overrun[1]), 1);
    chk("t3_hold55", int'(out_data), 'h55);
    cyc(0, 4'b0000, 0, 0, 0);
    chk("t3_still55", int'(out_data), 'h55);
    cyc(0, 4'b0000, 0, 1, 0);
    chk("t3_next33", int'(out_data), 'h33);
    cyc(0, 4'b0000, 0, 1, 0);
    chk("t3_66_dropped", int'(out_valid), 0);

    // overrun clear with a coincident drop, then a plain clear
    cyc(0, 4'b0010, 32'h0000_0100, 0, 0);
    cyc(0, 4'b0000, 0, 0, 0);
    cyc(0, 4'b0010, 32'h0000_0200, 0, 0);
    cyc(0, 4'b0010, 32'h0000_0300, 0, 4'b0010);
    chk("t6_set_wins", int'(overrun[1]), 1);
    cyc(0, 4'b0000, 0, 0, 4'b0010);
    chk("t6_cleared", int'(overrun[1]), 0);

    // reset mid-stream discards pending bytes
    cyc(1, 4'b0000, 0, 0, 0);
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_data", int'(out_data), 0);
    cyc(0, 4'b0000, 0, 1, 0);
    cyc(0, 4'b0000, 0, 1, 0);
    chk("t6_lost", int'(out_valid), 0);

    // drain+refill on ch0
    cyc(0, 4'b0001, 32'h0000_0011, 1, 0);
    cyc(0, 4'b0001, 32'h0000_007E, 1, 0);
    chk("t4_first", int'(out_data), 'h11);
    cyc(0, 4'b0000, 0, 1, 0);
    chk("t4_refill", int'(out_data), 'h7E);
    chk("t4_ch", int'(out_ch), 0);
    chk("t4_no_ov", int'(overrun[0]), 0);

    // fairness: ch0 refilled every cycle, ch3 pending
    cyc(1, 4'b0000, 0, 0, 0);
    cyc(0, 4'b1001, 32'h3C00_00C0, 1, 0);
    beat = 0;
    for (int b = 1; b <= 6; b++) begin
      cyc(0, 4'b0001, 32'h0000_00C0 + b, 1, 0);
      if (beat == 0 && out_valid && out_ch == 2'd3) beat = b;
    end
    chk("t5_ch3_within_4", int'(beat >= 1 && beat <= 4), 1);
    chk("t5_ch3_beat", beat, 2);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rrx = 4'($urandom & $urandom);
      cyc(($urandom % 200) == 0, rrx, $urandom, ($urandom % 4) != 0,
          (($urandom % 8) == 0) ? 4'($urandom) : 4'b0000);
    end

    cyc(0, 4'b0000, 0, 1, 0);
    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
